// File: rtl/bisection_sqrt_ctrl.sv
// rtl/bisection_sqrt_ctrl.sv - bisection floor(sqrt) controller driving an external adder
// The interval bounds lo/hi are the A/B output registers themselves; the adder forms lo+hi.
module bisection_sqrt_ctrl #(
   parameter int WIDTH   = 8,
   parameter int ADD_LAT = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   target,
   output logic [WIDTH-1:0]   A,
   output logic [WIDTH-1:0]   B,
   input  logic [WIDTH-1:0]   sum,
   output logic               busy,
   output logic               done,
   output logic [WIDTH/2-1:0] root,
   output logic [3:0]         iter
);

   typedef enum logic [1:0] {IDLE, ADD, EVAL, DONE} state_t;

   localparam logic [WIDTH-1:0] HI_INIT   = {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH/2);
   localparam logic [1:0]       WAIT_LAST = 2'(ADD_LAT);

   state_t           state;
   logic [WIDTH-1:0] c_q;
   logic [WIDTH-1:0] mid_q;
   logic [1:0]       wait_q;

   logic [WIDTH-1:0] sq;
   logic             mid_fits;
   logic [WIDTH-1:0] new_lo;
   logic [WIDTH-1:0] new_hi;
   logic [WIDTH-1:0] span;

   // mid < 2^(WIDTH/2), so the WIDTH-bit square cannot overflow.
   always_comb begin
      sq       = mid_q * mid_q;
      mid_fits = (sq <= c_q);
      new_lo   = mid_fits ? mid_q : A;
      new_hi   = mid_fits ? B : mid_q;
      span     = new_hi - new_lo;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         A      <= '0;
         B      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         root   <= '0;
         iter   <= '0;
         c_q    <= '0;
         mid_q  <= '0;
         wait_q <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  c_q    <= target;
                  A      <= '0;
                  B      <= HI_INIT;
                  iter   <= '0;
                  busy   <= 1'b1;
                  wait_q <= '0;
                  state  <= ADD;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            ADD: begin
               // A/B stay put until the adder result has settled.
               if (wait_q == WAIT_LAST) begin
                  mid_q  <= sum >> 1;
                  wait_q <= '0;
                  state  <= EVAL;
               end else begin
                  wait_q <= wait_q + 2'd1;
               end
            end
            EVAL: begin
               A    <= new_lo;
               B    <= new_hi;
               iter <= iter + 4'd1;
               if (span <= {{(WIDTH-1){1'b0}}, 1'b1}) begin
                  root  <= new_lo[WIDTH/2-1:0];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  state <= ADD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
